// File: rtl/sr_bank_ctrl.sv
// Ping-pong search-region bank controller: fills one bank while the other is scanned to the PE array.
// Latency: memory write same cycle as accept; first pe_valid two cycles after start is presented, ROWS reads back-to-back.
// Backpressure: load_ready drops while the target bank is full; a scan, once started, never stalls.
module sr_bank_ctrl #(
   parameter int DW   = 88,
   parameter int ROWS = 19
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_valid,
   input  logic [DW-1:0] load_data,
   output logic          load_ready,
   output logic          mem_write,
   output logic [5:0]    mem_addr_write,
   output logic [DW-1:0] mem_write_data,
   output logic          mem_read,
   output logic [5:0]    mem_addr_read,
   input  logic [DW-1:0] mem_read_data,
   input  logic          start,
   output logic          scan_ready,
   output logic          pe_valid,
   output logic [DW-1:0] pe_data,
   output logic [4:0]    pe_row,
   output logic          pe_last,
   output logic [1:0]    bank_full
);

   localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

   state_t     state_q, state_d;
   logic       rbank_q, rbank_d;
   logic [4:0] rrow_q, rrow_d;
   logic       wbank_q, wbank_d;
   logic [4:0] wrow_q, wrow_d;
   logic [1:0] bank_full_q, bank_full_d;
   logic       pe_valid_q, pe_valid_d;
   logic [4:0] pe_row_q, pe_row_d;
   logic       pe_last_q, pe_last_d;
   logic [1:0] fill_set;
   logic [1:0] drain_clr;

   // Fill side: accept beats into the write bank, write straight through, mark the bank full on its last row.
   always_comb begin
      load_ready     = !bank_full_q[wbank_q] && !rst;
      mem_write      = load_valid && load_ready;
      mem_addr_write = {wbank_q, wrow_q};
      mem_write_data = load_data;
      wbank_d        = wbank_q;
      wrow_d         = wrow_q;
      fill_set       = 2'b00;
      if (mem_write) begin
         if (wrow_q == LAST_ROW) begin
            fill_set[wbank_q] = 1'b1;
            wbank_d           = ~wbank_q;
            wrow_d            = 5'd0;
         end else begin
            wrow_d = wrow_q + 5'd1;
         end
      end
   end

   // Read side FSM: wait for a full bank, issue ROWS reads back-to-back, then release the bank.
   always_comb begin
      state_d       = state_q;
      rbank_d       = rbank_q;
      rrow_d        = rrow_q;
      mem_read      = 1'b0;
      mem_addr_read = {rbank_q, rrow_q};
      scan_ready    = 1'b0;
      drain_clr     = 2'b00;
      case (state_q)
         IDLE: begin
            scan_ready = bank_full_q[rbank_q] && !rst;
            if (start && scan_ready) begin
               state_d = SCAN;
               rrow_d  = 5'd0;
            end
         end
         SCAN: begin
            mem_read = !rst;
            if (rrow_q == LAST_ROW) begin
               state_d = DRAIN;
               rrow_d  = 5'd0;
            end else begin
               rrow_d = rrow_q + 5'd1;
            end
         end
         DRAIN: begin
            drain_clr[rbank_q] = 1'b1;
            rbank_d            = ~rbank_q;
            state_d            = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Bank flags: a release and a fill completion on opposite banks in one cycle both apply.
   always_comb begin
      bank_full_d = (bank_full_q & ~drain_clr) | fill_set;
      pe_valid_d  = mem_read;
      pe_row_d    = rrow_q;
      pe_last_d   = mem_read && (rrow_q == LAST_ROW);
   end

   // State registers with synchronous reset; reset abandons any partial fill or scan.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rbank_q     <= 1'b0;
         rrow_q      <= 5'd0;
         wbank_q     <= 1'b0;
         wrow_q      <= 5'd0;
         bank_full_q <= 2'b00;
         pe_valid_q  <= 1'b0;
         pe_row_q    <= 5'd0;
         pe_last_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rbank_q     <= rbank_d;
         rrow_q      <= rrow_d;
         wbank_q     <= wbank_d;
         wrow_q      <= wrow_d;
         bank_full_q <= bank_full_d;
         pe_valid_q  <= pe_valid_d;
         pe_row_q    <= pe_row_d;
         pe_last_q   <= pe_last_d;
      end
   end

   assign pe_valid  = pe_valid_q;
   assign pe_row    = pe_row_q;
   assign pe_last   = pe_last_q;
   assign pe_data   = mem_read_data;
   assign bank_full = bank_full_q;

endmodule

// File: tb/tb_sr_bank_ctrl.sv
// Directed bench for sr_bank_ctrl with a behavioural 64-entry search-region memory.
// Inputs change just after the falling edge; outputs are compared 1 time unit later.
// Each scenario task owns its stimulus and its expected values.
module tb_sr_bank_ctrl;
   localparam int DW   = 88;
   localparam int ROWS = 19;

   logic          clk = 1'b0;
   logic          rst;
   logic          load_valid;
   logic [DW-1:0] load_data;
   logic          load_ready;
   logic          mem_write;
   logic [5:0]    mem_addr_write;
   logic [DW-1:0] mem_write_data;
   logic          mem_read;
   logic [5:0]    mem_addr_read;
   logic [DW-1:0] mem_read_data;
   logic          start;
   logic          scan_ready;
   logic          pe_valid;
   logic [DW-1:0] pe_data;
   logic [4:0]    pe_row;
   logic          pe_last;
   logic [1:0]    bank_full;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mem [0:63];

   always #5 clk = ~clk;

   // Memory model: write on the edge, read data registered one cycle after mem_read.
   always @(posedge clk) begin
      if (mem_write) mem[mem_addr_write] <= mem_write_data;
      if (mem_read) mem_read_data <= mem[mem_addr_read];
   end

   sr_bank_ctrl #(.DW(DW), .ROWS(ROWS)) dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
      .mem_write(mem_write), .mem_addr_write(mem_addr_write), .mem_write_data(mem_write_data),
      .mem_read(mem_read), .mem_addr_read(mem_addr_read), .mem_read_data(mem_read_data),
      .start(start), .scan_ready(scan_ready),
      .pe_valid(pe_valid), .pe_data(pe_data), .pe_row(pe_row), .pe_last(pe_last),
      .bank_full(bank_full)
   );

   task automatic step;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1; load_valid = 1'b1; load_data = '0; start = 1'b1;
      step; step; #1;
      checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL rst_load_ready got=%0h exp=0", load_ready); end
      checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_mem_write got=%0h exp=0", mem_write); end
      checks++; if (scan_ready !== 1'b0) begin errors++; $display("FAIL rst_scan_ready got=%0h exp=0", scan_ready); end
      checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL rst_mem_read got=%0h exp=0", mem_read); end
      checks++; if (bank_full !== 2'b00) begin errors++; $display("FAIL rst_bank_full got=%0h exp=0", bank_full); end
      checks++; if (pe_valid !== 1'b0) begin errors++; $display("FAIL rst_pe_valid got=%0h exp=0", pe_valid); end
      checks++; if (pe_last !== 1'b0) begin errors++; $display("FAIL rst_pe_last got=%0h exp=0", pe_last); end
      checks++; if (pe_row !== 5'd0) begin errors++; $display("FAIL rst_pe_row got=%0h exp=0", pe_row); end
      rst = 1'b0; load_valid = 1'b0; start = 1'b0;
      step;
   endtask

   task automatic test_fill_bank0;
      for (int r = 0; r < ROWS; r++) begin
         load_valid = 1'b1; load_data = DW'(r); #1;
         checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL fill0_write row %0d got=%0h exp=1", r, mem_write); end
         checks++; if (mem_addr_write !== 6'(r)) begin errors++; $display("FAIL fill0_addr got=%0h exp=%0h", mem_addr_write, 6'(r)); end
         checks++; if (mem_write_data !== DW'(r)) begin errors++; $display("FAIL fill0_data got=%0h exp=%0h", mem_write_data, r); end
         checks++; if (bank_full !== 2'b00) begin errors++; $display("FAIL fill0_full_early row %0d got=%0h exp=0", r, bank_full); end
         step;
      end
      load_valid = 1'b0; #1;
      checks++; if (bank_full !== 2'b01) begin errors++; $display("FAIL fill0_full got=%0h exp=1", bank_full); end
      checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL fill0_ready_bank1 got=%0h exp=1", load_ready); end
      load_valid = 1'b1; load_data = DW'(100); #1;
      checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL beat20_write got=%0h exp=1", mem_write); end
      checks++; if (mem_addr_write !== 6'h20) begin errors++; $display("FAIL beat20_addr got=%0h exp=20", mem_addr_write); end
      step;
   endtask

   task automatic test_both_full;
      for (int r = 1; r < ROWS; r++) begin
         load_valid = 1'b1; load_data = DW'(100 + r); #1;
         checks++; if (mem_addr_write !== 6'h20 + 6'(r)) begin errors++; $display("FAIL fill1_addr got=%0h exp=%0h", mem_addr_write, 6'h20 + 6'(r)); end
         step;
      end
      load_valid = 1'b1; load_data = DW'(999); #1;
      checks++; if (bank_full !== 2'b11) begin errors++; $display("FAIL both_full got=%0h exp=3", bank_full); end
      checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL both_full_ready got=%0h exp=0", load_ready); end
      checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL beat39_write got=%0h exp=0", mem_write); end
      step; #1;
      checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL beat39_held got=%0h exp=0", mem_write); end
      checks++; if (bank_full !== 2'b11) begin errors++; $display("FAIL beat39_full got=%0h exp=3", bank_full); end
      load_valid = 1'b0;
   endtask

   task automatic test_scan_bank0;
      #1;
      checks++; if (scan_ready !== 1'b1) begin errors++; $display("FAIL scan0_ready got=%0h exp=1", scan_ready); end
      start = 1'b1; step; start = 1'b0;
      for (int i = 0; i < ROWS; i++) begin
         #1;
         checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL scan0_read cyc %0d got=%0h exp=1", i, mem_read); end
         checks++; if (mem_addr_read !== 6'(i)) begin errors++; $display("FAIL scan0_addr got=%0h exp=%0h", mem_addr_read, 6'(i)); end
         if (i > 0) begin
            checks++; if (pe_valid !== 1'b1) begin errors++; $display("FAIL scan0_pe_valid cyc %0d got=%0h exp=1", i, pe_valid); end
            checks++; if (pe_row !== 5'(i - 1)) begin errors++; $display("FAIL scan0_pe_row got=%0h exp=%0h", pe_row, i - 1); end
            checks++; if (pe_data !== DW'(i - 1)) begin errors++; $display("FAIL scan0_pe_data got=%0h exp=%0h", pe_data, i - 1); end
            checks++; if (pe_last !== 1'b0) begin errors++; $display("FAIL scan0_pe_last_early cyc %0d got=%0h exp=0", i, pe_last); end
         end else begin
            checks++; if (pe_valid !== 1'b0) begin errors++; $display("FAIL scan0_pe_valid_first got=%0h exp=0", pe_valid); end
         end
         step;
      end
      #1;
      checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL drain_read got=%0h exp=0", mem_read); end
      checks++; if (pe_valid !== 1'b1) begin errors++; $display("FAIL drain_pe_valid got=%0h exp=1", pe_valid); end
      checks++; if (pe_row !== 5'd18) begin errors++; $display("FAIL drain_pe_row got=%0h exp=12", pe_row); end
      checks++; if (pe_data !== DW'(18)) begin errors++; $display("FAIL drain_pe_data got=%0h exp=12", pe_data); end
      checks++; if (pe_last !== 1'b1) begin errors++; $display("FAIL drain_pe_last got=%0h exp=1", pe_last); end
      checks++; if (bank_full !== 2'b11) begin errors++; $display("FAIL drain_full got=%0h exp=3", bank_full); end
      step; #1;
      checks++; if (pe_valid !== 1'b0) begin errors++; $display("FAIL post_scan_pe_valid got=%0h exp=0", pe_valid); end
      checks++; if (pe_last !== 1'b0) begin errors++; $display("FAIL post_scan_pe_last got=%0h exp=0", pe_last); end
      checks++; if (bank_full !== 2'b10) begin errors++; $display("FAIL post_scan_full got=%0h exp=2", bank_full); end
      checks++; if (scan_ready !== 1'b1) begin errors++; $display("FAIL post_scan_ready_bank1 got=%0h exp=1", scan_ready); end
   endtask

   task automatic test_reset_mid_scan;
      start = 1'b1; step; start = 1'b0;
      for (int i = 0; i < 7; i++) step;
      #1;
      checks++; if (mem_addr_read !== 6'h27) begin errors++; $display("FAIL mid_scan_addr got=%0h exp=27", mem_addr_read); end
      rst = 1'b1; #1;
      checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL mid_rst_mem_read got=%0h exp=0", mem_read); end
      step; #1;
      checks++; if (pe_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_pe_valid got=%0h exp=0", pe_valid); end
      checks++; if (bank_full !== 2'b00) begin errors++; $display("FAIL mid_rst_full got=%0h exp=0", bank_full); end
      checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready_held got=%0h exp=0", load_ready); end
      rst = 1'b0; #1;
      checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got=%0h exp=1", load_ready); end
      checks++; if (scan_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_scan_ready got=%0h exp=0", scan_ready); end
      load_valid = 1'b1; load_data = '0; #1;
      checks++; if (mem_addr_write !== 6'h00) begin errors++; $display("FAIL mid_rst_next_addr got=%0h exp=0", mem_addr_write); end
      load_valid = 1'b0;
      step; #1;
      checks++; if (pe_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_pe_valid_after got=%0h exp=0", pe_valid); end
   endtask

   task automatic test_start_empty;
      for (int k = 0; k < 3; k++) begin
         start = 1'b1; #1;
         checks++; if (scan_ready !== 1'b0) begin errors++; $display("FAIL empty_scan_ready got=%0h exp=0", scan_ready); end
         checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL empty_mem_read got=%0h exp=0", mem_read); end
         step;
      end
      start = 1'b0; #1;
      checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL empty_not_remembered got=%0h exp=0", mem_read); end
      for (int r = 0; r < ROWS; r++) begin
         load_valid = 1'b1; load_data = DW'(50 + r); #1;
         checks++; if (scan_ready !== 1'b0) begin errors++; $display("FAIL refill_scan_ready_early row %0d got=%0h exp=0", r, scan_ready); end
         step;
      end
      load_valid = 1'b0; #1;
      checks++; if (scan_ready !== 1'b1) begin errors++; $display("FAIL refill_scan_ready got=%0h exp=1", scan_ready); end
      checks++; if (bank_full !== 2'b01) begin errors++; $display("FAIL refill_full got=%0h exp=1", bank_full); end
   endtask

   task automatic test_concurrent;
      start = 1'b1; step; start = 1'b0;
      for (int i = 0; i < ROWS; i++) begin
         load_valid = (i > 0); load_data = DW'(200 + i - 1); #1;
         checks++; if (mem_addr_read !== 6'(i) || mem_read !== 1'b1) begin errors++; $display("FAIL conc_read got=%0h/%0h exp=1/%0h", mem_read, mem_addr_read, 6'(i)); end
         if (i > 0) begin
            checks++; if (mem_write !== 1'b1 || mem_addr_write !== 6'h20 + 6'(i - 1)) begin errors++; $display("FAIL conc_write got=%0h/%0h exp=1/%0h", mem_write, mem_addr_write, 6'h20 + 6'(i - 1)); end
            checks++; if (pe_valid !== 1'b1 || pe_data !== DW'(50 + i - 1)) begin errors++; $display("FAIL conc_pe got=%0h/%0h exp=1/%0h", pe_valid, pe_data, 50 + i - 1); end
         end else begin
            checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL conc_write_idle got=%0h exp=0", mem_write); end
         end
         step;
      end
      load_valid = 1'b1; load_data = DW'(218); #1;
      checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL conc_drain_read got=%0h exp=0", mem_read); end
      checks++; if (mem_write !== 1'b1 || mem_addr_write !== 6'h32) begin errors++; $display("FAIL conc_drain_write got=%0h/%0h exp=1/32", mem_write, mem_addr_write); end
      checks++; if (bank_full !== 2'b01) begin errors++; $display("FAIL conc_drain_full got=%0h exp=1", bank_full); end
      checks++; if (pe_last !== 1'b1 || pe_data !== DW'(68)) begin errors++; $display("FAIL conc_drain_pe got=%0h/%0h exp=1/44", pe_last, pe_data); end
      step; load_valid = 1'b0; #1;
      checks++; if (bank_full !== 2'b10) begin errors++; $display("FAIL conc_set_clear got=%0h exp=2", bank_full); end
      checks++; if (scan_ready !== 1'b1) begin errors++; $display("FAIL conc_scan_ready got=%0h exp=1", scan_ready); end
      checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL conc_load_ready got=%0h exp=1", load_ready); end
      start = 1'b1; step; start = 1'b0;
      for (int i = 0; i <= ROWS; i++) begin
         #1;
         if (i > 0) begin
            checks++; if (pe_valid !== 1'b1 || pe_row !== 5'(i - 1)) begin errors++; $display("FAIL scan1_pe got=%0h/%0h exp=1/%0h", pe_valid, pe_row, i - 1); end
            checks++; if (pe_data !== DW'(200 + i - 1)) begin errors++; $display("FAIL scan1_pe_data got=%0h exp=%0h", pe_data, 200 + i - 1); end
            checks++; if (pe_last !== 1'(i == ROWS)) begin errors++; $display("FAIL scan1_pe_last cyc %0d got=%0h", i, pe_last); end
         end
         step;
      end
      #1;
      checks++; if (bank_full !== 2'b00 || scan_ready !== 1'b0) begin errors++; $display("FAIL scan1_release got=%0h/%0h exp=0/0", bank_full, scan_ready); end
   endtask

   initial begin
      rst = 1'b1; load_valid = 1'b0; load_data = '0; start = 1'b0;
      test_reset;
      test_fill_bank0;
      test_both_full;
      test_scan_bank0;
      test_reset_mid_scan;
      test_start_empty;
      test_concurrent;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sr_bank_ctrl.md
SR_BANK_CTRL -- requirements
Module: sr_bank_ctrl

Interface
REQ-001 The block SHALL have parameter DW, default 88, meaning search-region row width in bits.
REQ-002 The block SHALL have parameter ROWS, default 19, meaning rows per bank, legal range 2..32.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
REQ-004 The block SHALL have these load-side ports:
- load_valid  in  1  row beat offered
- load_data  in  DW  row beat payload
- load_ready  out  1  beat accepted when load_valid && load_ready
REQ-005 The block SHALL have these memory-side ports:
- mem_write  out  1  memory write enable
- mem_addr_write  out  6  write address {bank, row[4:0]}
- mem_write_data  out  DW  write payload
- mem_read  out  1  memory read enable
- mem_addr_read  out  6  read address {bank, row[4:0]}
- mem_read_data  in  DW  memory read data, valid one cycle after mem_read
REQ-006 The block SHALL have these scan-side ports:
- start  in  1  request scan of current read bank
- scan_ready  out  1  start will be honoured this cycle
- pe_valid  out  1  pe_data valid
- pe_data  out  DW  row to PE array
- pe_row  out  5  row index of pe_data
- pe_last  out  1  final row of scan; doubles as done pulse
- bank_full  out  2  per-bank filled flags

Function
REQ-007 Address encoding SHALL be bit5 = bank and bits[4:0] = row 0..ROWS-1; rows ROWS..31 SHALL never be driven.
REQ-008 The fill side SHALL keep state wbank (1 bit) and wrow (5 bits); load_ready SHALL equal !bank_full[wbank] && !rst.
REQ-009 Each accepted beat SHALL drive, in the same cycle, mem_write=1, mem_addr_write={wbank,wrow} and mem_write_data=load_data; mem_write SHALL be 0 otherwise.
REQ-010 After the beat with wrow=ROWS-1: bank_full[wbank] SHALL set, wbank SHALL toggle and wrow SHALL clear to 0 on the next edge; otherwise wrow SHALL increment.
REQ-011 The read side SHALL be an FSM with states IDLE, SCAN and DRAIN, plus state rbank (1 bit) and rrow (5 bits).
REQ-012 scan_ready SHALL be 1 exactly when state=IDLE && bank_full[rbank].
REQ-013 start with scan_ready=1 SHALL move IDLE->SCAN with rrow=0; start with scan_ready=0 SHALL be ignored and not remembered.
REQ-014 In SCAN, each cycle SHALL drive mem_read=1 and mem_addr_read={rbank,rrow}, then increment rrow; after issuing rrow=ROWS-1 the FSM SHALL go to DRAIN.
REQ-015 The scan SHALL be non-stallable: exactly ROWS consecutive reads per scan.
REQ-016 In DRAIN (one cycle): bank_full[rbank] SHALL clear, rbank SHALL toggle and the FSM SHALL return to IDLE.
REQ-017 mem_read SHALL be 0 in IDLE and DRAIN.
REQ-018 pe_valid and pe_row SHALL be mem_read and rrow registered by one cycle.
REQ-019 pe_data SHALL equal mem_read_data, combinational pass-through.
REQ-020 pe_last SHALL be 1 with the pe_valid of row ROWS-1.
REQ-021 Scan latency: first pe_valid two cycles after the accepted start edge; last pe_valid ROWS+1 cycles after it.
REQ-022 A fill into one bank while the other bank is scanned SHALL proceed concurrently with no stall and no address collision.
REQ-023 A filled bank SHALL never be written before its release.
REQ-024 When a bank_full set (fill side) and a bank_full clear (DRAIN) land in the same cycle on different banks, both SHALL take effect.
REQ-025 A fill completing on the bank in rbank while in IDLE SHALL make scan_ready rise the next cycle.

Reset
REQ-026 While rst is high at a clock edge: FSM=IDLE, wbank=rbank=0, wrow=rrow=0, bank_full=00, pe_valid=pe_last=0, pe_row=0.
REQ-027 Combinational outputs mem_write, mem_read, load_ready and scan_ready SHALL be 0 while rst is high.
REQ-028 Reset mid-scan or mid-fill SHALL abandon the operation; the partial bank is not valid; pe_valid SHALL be 0 from the cycle after the reset edge.

Verification
REQ-029 Fill bank 0: reset, then 19 beats with load_data = row index -> mem_addr_write 0x00..0x12, bank_full=01 after the 19th beat, and the 20th beat writes 0x20.
REQ-030 Both banks full: 38 beats -> bank_full=11 and load_ready=0; a 39th beat is held and no mem_write occurs.
REQ-031 Scan bank 0: start with bank 0 full -> mem_addr_read 0x00..0x12 on 19 consecutive cycles; pe_valid on 19 cycles with pe_row 0..18 and pe_data = 0..18; pe_last only on row 18; bank_full[0] clears in the following cycle.
REQ-032 Start with bank_full=00 -> scan_ready=0, no mem_read, FSM stays IDLE; a later fill then start scans normally.
REQ-033 Concurrent fill of bank 1 during the bank 0 scan -> writes at 0x20..0x32 interleave with reads at 0x00..0x12; after DRAIN, rbank=1 and scan_ready=1.
REQ-034 Reset asserted at scan row 7 -> next cycle pe_valid=0, bank_full=00 and load_ready=1 once rst deasserts; the next fill targets 0x00.
